// File: rtl/bp_perf_pkg.sv
// Shared types and constants for the branch-predictor performance monitor.
// Holds the FSM state enum, read-selector enum, default widths and ID word.
package bp_perf_pkg;

    localparam int          CNT_W_DEF    = 32;
    localparam int          STREAK_W_DEF = 16;
    localparam logic [31:0] PERF_ID      = 32'hB9E5_0001;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FROZEN = 2'd1,
        ST_CLEAR  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEL_CYC    = 3'd0,
        SEL_RET    = 3'd1,
        SEL_BR     = 3'd2,
        SEL_MP     = 3'd3,
        SEL_LASTPC = 3'd4,
        SEL_MAXSTR = 3'd5,
        SEL_STATUS = 3'd6,
        SEL_ID     = 3'd7
    } sel_e;

endpackage

// File: rtl/bp_perf_mon_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: i_clk, i_reset, i_clr (zero), i_inc (count up), o_cnt (value).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/bp_perf_mon.sv
// Branch-predictor performance monitor: cycle/retire/branch/mispredict
// counters, mispredict streaks, last mispredict PC and a 1-cycle read port.
// Ports: i_clk, i_reset (sync, high), i_insn_vld/i_ctrl/i_mispred/i_pc_debug
// (retire events), i_clear, i_freeze, i_rd_req/i_rd_sel -> o_rd_valid,
// o_rd_data, o_proto_err (sticky mispredict-without-control flag).
module bp_perf_mon
    import bp_perf_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int STREAK_W = STREAK_W_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_insn_vld,
    input  logic        i_ctrl,
    input  logic        i_mispred,
    input  logic [31:0] i_pc_debug,
    input  logic        i_clear,
    input  logic        i_freeze,
    input  logic        i_rd_req,
    input  logic [2:0]  i_rd_sel,
    output logic        o_rd_valid,
    output logic [31:0] o_rd_data,
    output logic        o_proto_err
);

    localparam int CXW = (CNT_W > 32) ? CNT_W : 32;
    localparam int SXW = (STREAK_W > 32) ? STREAK_W : 32;

    state_e               r_state;
    logic [31:0]          r_last_pc;
    logic [STREAK_W-1:0]  r_max_streak;

    logic                 w_clr;
    logic                 w_run;
    logic                 w_ret_ev;
    logic                 w_br_ev;
    logic                 w_mp_ev;
    logic                 w_ok_ev;
    logic                 w_proto;
    logic [CNT_W-1:0]     w_cyc;
    logic [CNT_W-1:0]     w_ret;
    logic [CNT_W-1:0]     w_br;
    logic [CNT_W-1:0]     w_mp;
    logic [STREAK_W-1:0]  w_cur;
    logic [CXW-1:0]       w_cyc_x;
    logic [CXW-1:0]       w_ret_x;
    logic [CXW-1:0]       w_br_x;
    logic [CXW-1:0]       w_mp_x;
    logic [SXW-1:0]       w_max_x;
    logic [31:0]          w_rd_mux;

    // A clear request wipes statistics at once; the event that came with
    // it is dropped because counting requires a non-clearing RUN cycle.
    assign w_clr    = (r_state == ST_CLEAR) || i_clear;
    assign w_run    = (r_state == ST_RUN) && !i_clear && !i_freeze;
    assign w_ret_ev = w_run && i_insn_vld;
    assign w_br_ev  = w_ret_ev && i_ctrl;
    assign w_mp_ev  = w_br_ev && i_mispred;
    assign w_ok_ev  = w_br_ev && !i_mispred;
    assign w_proto  = i_insn_vld && !i_ctrl && i_mispred;

    sat_counter #(.W(CNT_W)) u_cyc (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_clr),
        .i_inc   (w_run),
        .o_cnt   (w_cyc)
    );

    sat_counter #(.W(CNT_W)) u_ret (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_clr),
        .i_inc   (w_ret_ev),
        .o_cnt   (w_ret)
    );

    sat_counter #(.W(CNT_W)) u_br (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_clr),
        .i_inc   (w_br_ev),
        .o_cnt   (w_br)
    );

    sat_counter #(.W(CNT_W)) u_mp (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_clr),
        .i_inc   (w_mp_ev),
        .o_cnt   (w_mp)
    );

    sat_counter #(.W(STREAK_W)) u_cur (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_clr || w_ok_ev),
        .i_inc   (w_mp_ev),
        .o_cnt   (w_cur)
    );

    // The streak only grows by one, and never exceeds the recorded
    // maximum, so a new maximum appears exactly when they are equal.
    always_ff @(posedge i_clk) begin
        if (i_reset || w_clr) begin
            r_max_streak <= '0;
        end else if (w_mp_ev && (w_cur == r_max_streak)
                     && (r_max_streak != {STREAK_W{1'b1}})) begin
            r_max_streak <= r_max_streak + STREAK_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || w_clr) begin
            r_last_pc <= '0;
        end else if (w_mp_ev) begin
            r_last_pc <= i_pc_debug;
        end
    end

    // A protocol error seen in the same cycle as a clear still sticks.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_proto_err <= 1'b0;
        end else if (w_proto) begin
            o_proto_err <= 1'b1;
        end else if (w_clr) begin
            o_proto_err <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_CLEAR;
        end else begin
            unique case (r_state)
                ST_CLEAR: begin
                    r_state <= i_freeze ? ST_FROZEN : ST_RUN;
                end
                ST_RUN: begin
                    if (i_clear) begin
                        r_state <= ST_CLEAR;
                    end else if (i_freeze) begin
                        r_state <= ST_FROZEN;
                    end
                end
                ST_FROZEN: begin
                    if (i_clear) begin
                        r_state <= ST_CLEAR;
                    end else if (!i_freeze) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                end
            endcase
        end
    end

    assign w_cyc_x = CXW'(w_cyc);
    assign w_ret_x = CXW'(w_ret);
    assign w_br_x  = CXW'(w_br);
    assign w_mp_x  = CXW'(w_mp);
    assign w_max_x = SXW'(r_max_streak);

    always_comb begin
        w_rd_mux = '0;
        case (sel_e'(i_rd_sel))
            SEL_CYC:    w_rd_mux = w_cyc_x[31:0];
            SEL_RET:    w_rd_mux = w_ret_x[31:0];
            SEL_BR:     w_rd_mux = w_br_x[31:0];
            SEL_MP:     w_rd_mux = w_mp_x[31:0];
            SEL_LASTPC: w_rd_mux = r_last_pc;
            SEL_MAXSTR: w_rd_mux = w_max_x[31:0];
            SEL_STATUS: w_rd_mux = {28'b0, o_proto_err, r_state, i_freeze};
            SEL_ID:     w_rd_mux = PERF_ID;
            default:    w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            o_rd_valid <= i_rd_req;
            if (i_rd_req) begin
                o_rd_data <= w_rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_bp_perf_mon.sv
// Scoreboard bench for bp_perf_mon against a rule-level reference model.
// Directed scenarios first, then randomized retire/clear/freeze/read traffic.
module tb_bp_perf_mon;
    import bp_perf_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic        ctrl;
    logic        misp;
    logic [31:0] pc;
    logic        clr;
    logic        frz;
    logic        rd_req;
    logic [2:0]  rd_sel;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        perr;

    always #5 clk = ~clk;

    bp_perf_mon dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_insn_vld  (vld),
        .i_ctrl      (ctrl),
        .i_mispred   (misp),
        .i_pc_debug  (pc),
        .i_clear     (clr),
        .i_freeze    (frz),
        .i_rd_req    (rd_req),
        .i_rd_sel    (rd_sel),
        .o_rd_valid  (rd_valid),
        .o_rd_data   (rd_data),
        .o_proto_err (perr)
    );

    int errs = 0;
    int checks = 0;
    logic [31:0] expq[$];

    logic [31:0] m_cyc, m_ret, m_br, m_mp, m_pc;
    logic [15:0] m_cur, m_max;
    logic        m_perr;
    state_e      m_st;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] rd_exp(input logic [2:0] s,
                                           input logic f);
        logic [1:0] st;
        st = m_st;
        case (s)
            3'd0: return m_cyc;
            3'd1: return m_ret;
            3'd2: return m_br;
            3'd3: return m_mp;
            3'd4: return m_pc;
            3'd5: return {16'b0, m_max};
            3'd6: return {28'b0, m_perr, st, f};
            default: return 32'hB9E5_0001;
        endcase
    endfunction

    // Monitor: every valid read pops the oldest expectation.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL rd_unexpected got=%h exp=none", rd_data);
            end else begin
                chk("rd_data", rd_data, expq.pop_front());
            end
        end
    end

    task automatic step(input logic r, input logic v, input logic c,
                        input logic m, input logic [31:0] p,
                        input logic cl, input logic f,
                        input logic rq, input logic [2:0] s);
        logic cnt_ok, prot, clrnow;
        rst = r; vld = v; ctrl = c; misp = m; pc = p;
        clr = cl; frz = f; rd_req = rq; rd_sel = s;
        if (r) begin
            m_cyc = 0; m_ret = 0; m_br = 0; m_mp = 0; m_pc = 0;
            m_cur = 0; m_max = 0; m_perr = 0; m_st = ST_CLEAR;
        end else begin
            if (rq) expq.push_back(rd_exp(s, f));
            cnt_ok = (m_st == ST_RUN) && !cl && !f;
            prot   = v && !c && m;
            clrnow = (m_st == ST_CLEAR) || cl;
            if (cnt_ok) begin
                m_cyc = inc32(m_cyc);
                if (v) begin
                    m_ret = inc32(m_ret);
                    if (c) begin
                        m_br = inc32(m_br);
                        if (m) begin
                            m_mp  = inc32(m_mp);
                            m_pc  = p;
                            m_cur = inc16(m_cur);
                            if (m_cur > m_max) m_max = m_cur;
                        end else begin
                            m_cur = 0;
                        end
                    end
                end
            end
            if (clrnow) begin
                m_cyc = 0; m_ret = 0; m_br = 0; m_mp = 0; m_pc = 0;
                m_cur = 0; m_max = 0;
            end
            if (prot) m_perr = 1'b1;
            else if (clrnow) m_perr = 1'b0;
            case (m_st)
                ST_CLEAR:  m_st = f ? ST_FROZEN : ST_RUN;
                ST_RUN:    m_st = cl ? ST_CLEAR : (f ? ST_FROZEN : ST_RUN);
                default:   m_st = cl ? ST_CLEAR : (f ? ST_FROZEN : ST_RUN);
            endcase
        end
        @(posedge clk);
        #1;
        chk("proto_err", {31'b0, perr}, {31'b0, m_perr});
        if (r && rq) chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    endtask

    task automatic ev(input logic v, input logic c, input logic m,
                      input logic [31:0] p);
        step(0, v, c, m, p, 0, 0, 0, 3'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 3'd0);
    endtask

    task automatic rd(input logic [2:0] s);
        step(0, 0, 0, 0, 0, 0, 0, 1, s);
    endtask

    task automatic do_clear();
        step(0, 0, 0, 0, 0, 1, 0, 0, 3'd0);
        idle(1);
    endtask

    initial begin
        logic f_lvl;
        rst = 1; vld = 0; ctrl = 0; misp = 0; pc = 0;
        clr = 0; frz = 0; rd_req = 0; rd_sel = 0;
        #2;
        step(1, 0, 0, 0, 0, 0, 0, 1, 3'd0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 3'd0);
        for (int s = 0; s < 8; s++) rd(3'(s));

        // 10 cycles: 4 retires, 2 branches, 1 mispredict at 0x40
        do_clear();
        ev(1, 0, 0, 32'h10);
        ev(1, 1, 0, 32'h14);
        ev(1, 1, 1, 32'h40);
        ev(1, 0, 0, 32'h44);
        idle(6);
        rd(3'd1); rd(3'd2); rd(3'd3); rd(3'd4);

        // near-saturation of the retire counter
        do_clear();
        force dut.u_ret.r_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.u_ret.r_cnt;
        m_ret = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) ev(1, 0, 0, 32'h100);
        rd(3'd1);

        // streak M,M,M,correct,M
        do_clear();
        ev(1, 1, 1, 32'h200); ev(1, 1, 1, 32'h204); ev(1, 1, 1, 32'h208);
        ev(1, 1, 0, 32'h20C); ev(1, 1, 1, 32'h210);
        rd(3'd5);
        chk("cur_streak", {16'b0, dut.w_cur}, {16'b0, m_cur});

        // clear together with a mispredicting retire
        ev(1, 1, 1, 32'h300);
        step(0, 1, 1, 1, 32'h304, 1, 0, 0, 3'd0);
        rd(3'd3); rd(3'd6); rd(3'd6);

        // freeze with events present
        idle(2);
        rd(3'd0);
        for (int i = 0; i < 5; i++)
            step(0, 1, 1, i[0], 32'h400, 0, 1, 1, 3'(i % 2 == 0 ? 0 : 6));
        rd(3'd0); rd(3'd1);

        // mispredict without control transfer
        ev(1, 0, 1, 32'h500);
        rd(3'd3);
        idle(3);
        rd(3'd6);
        do_clear();
        rd(3'd6);

        f_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic v, c, m, cl, r;
            if ($urandom_range(99) < 5) f_lvl = ~f_lvl;
            v  = ($urandom_range(3) != 0);
            c  = ($urandom_range(1) == 1);
            m  = c ? ($urandom_range(9) < 5) : ($urandom_range(99) < 3);
            cl = ($urandom_range(99) < 2);
            r  = ($urandom_range(999) < 5);
            step(r, v, c, m, $urandom, cl, f_lvl,
                 $urandom_range(1) == 1, 3'($urandom_range(7)));
        end

        idle(3);
        chk("drain", expq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
